level_tracker: RTL and testbench
================================

Name: level_tracker

Overview:
- Parametrised game-progression tracker for the Blink design. Counts success pulses per level, advances through NUM_LEVELS levels and declares a win after the last level.
- Tracks a configurable number of lives. A miss either restarts play at level 1 or drops one level, depending on MISS_MODE.
- Sits between the input-judging logic (hit/miss pulses) and the display/scoring logic, which consume level, lives and the status flags.

Parameters:
NUM_LEVELS, 4, number of playable levels (>=2); level is reported 1-based.
HITS_PER_LEVEL, 2, consecutive hits required to clear a level (>=1).
LIVES, 3, misses tolerated; the LIVES-th miss ends the game (>=1).
MISS_MODE, 0, 0 = a miss returns to level 1; 1 = a miss drops one level, floored at 1.
Derived localparams: LVL_W = $clog2(NUM_LEVELS+1), LIFE_W = $clog2(LIVES+1), CNT_W = max(1, $clog2(HITS_PER_LEVEL)).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clock clk
hit  input  1  1-cycle pulse: player succeeded
miss  input  1  1-cycle pulse: player failed
start  input  1  restart request, honoured only in WIN or OVER
level  output  LVL_W  current level, 1..NUM_LEVELS (registered)
lives_left  output  LIFE_W  remaining lives, LIVES..0 (registered)
level_up  output  1  1-cycle pulse on the cycle after a level advance
level_down  output  1  1-cycle pulse on the cycle after a miss-induced level decrease
win  output  1  high while in WIN
game_over  output  1  high while in OVER

Behaviour:
- All outputs are registered; each responds one cycle after the triggering input edge.
- Reset values: state=PLAY, level=1, lives_left=LIVES, hit_cnt=0, level_up=0, level_down=0, win=0, game_over=0.
- Reset overrides every other input on the same edge.
- States: PLAY, WIN, OVER, using a 2-bit encoding. Unused encodings go to PLAY with reset values.
- PLAY, hit=1 and miss=0:
  - If hit_cnt < HITS_PER_LEVEL-1: hit_cnt++.
  - Otherwise hit_cnt=0, then:
    - if level < NUM_LEVELS: level++ and level_up=1;
    - if level == NUM_LEVELS: go to WIN, level held, no level_up.
- PLAY, miss=1 (miss has priority; a simultaneous hit is discarded):
  - hit_cnt=0.
  - If lives_left == 1: lives_left=0, go to OVER, level held, no level_down.
  - Otherwise lives_left--, then:
    - MISS_MODE=0: level=1;
    - MISS_MODE=1: level=level-1 if level>1, else stays 1.
  - level_down=1 only if level actually decreased. A miss at level 1 gives no pulse.
- PLAY, no hit and no miss: everything holds; the pulse outputs return to 0.
- WIN/OVER: hit and miss are ignored; level, lives_left and hit_cnt hold; win/game_over stay high.
- WIN/OVER with start=1: return to PLAY with reset values on the next edge. start is ignored in PLAY.
- level_up and level_down are never high in the same cycle. win and game_over are mutually exclusive.
- No arithmetic wraps: level is bounded to 1..NUM_LEVELS and lives_left to 0..LIVES by the rules above.

Test Plan (defaults unless noted):
- Reset, then 8 single-cycle hit pulses → level 1→2→3→4 (level_up after hits 2, 4, 6), win=1 after hit 8, level stays 4; further hits leave outputs unchanged.
- Reach level 3, then one miss (MISS_MODE=0) → level=1, lives_left=2, level_down pulse 1 cycle; the next single hit does not advance (hit_cnt was cleared).
- MISS_MODE=1: reach level 3, miss → level=2, lives_left=2; miss again → level=1; miss at level 1 → game_over=1, lives_left=0, no level_down.
- hit and miss asserted in the same cycle at level 2 with hit_cnt=1 → treated as miss: lives_left decrements, hit_cnt=0, no level_up.
- From OVER: hit/miss ignored; start=1 → next cycle PLAY, level=1, lives_left=3, game_over=0. start pulsed in PLAY has no effect.
- Reset asserted mid-game (level 3, lives_left 1) together with hit → next cycle all reset values, no pulses. Repeat with NUM_LEVELS=8, HITS_PER_LEVEL=1: 8 hits → win, level=8.

Source files
------------

// File: rtl/level_tracker.sv
// level_tracker: game-progression tracker for Blink.
// Counts hits per level, tracks lives, flags win / game over.
module level_tracker #(
  parameter  int NUM_LEVELS     = 4,
  parameter  int HITS_PER_LEVEL = 2,
  parameter  int LIVES          = 3,
  parameter  int MISS_MODE      = 0,
  localparam int LVL_W  = $clog2(NUM_LEVELS + 1),
  localparam int LIFE_W = $clog2(LIVES + 1),
  localparam int CNT_W  = (HITS_PER_LEVEL > 2) ?
                          $clog2(HITS_PER_LEVEL) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hit,
  input  logic              miss,
  input  logic              start,
  output logic [LVL_W-1:0]  level,
  output logic [LIFE_W-1:0] lives_left,
  output logic              level_up,
  output logic              level_down,
  output logic              win,
  output logic              game_over
);

  typedef enum logic [1:0] {
    S_PLAY = 2'b00,
    S_WIN  = 2'b01,
    S_OVER = 2'b10
  } state_e;

  localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0]  LVL_MAX  = LVL_W'(NUM_LEVELS);
  localparam logic [LIFE_W-1:0] LIFE_ONE = LIFE_W'(1);
  localparam logic [LIFE_W-1:0] LIFE_MAX = LIFE_W'(LIVES);
  localparam logic [CNT_W-1:0]  CNT_MAX  =
    CNT_W'(HITS_PER_LEVEL - 1);

  state_e              state_q, state_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [LIFE_W-1:0]   lives_q, lives_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                up_q, up_d;
  logic                down_q, down_d;
  logic                win_q, win_d;
  logic                over_q, over_d;

  // Next-state and next-output logic for the game FSM.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    case (state_q)
      S_PLAY: begin
        if (miss) begin
          cnt_d = '0;
          if (lives_q == LIFE_ONE) begin
            lives_d = '0;
            state_d = S_OVER;
          end else begin
            lives_d = lives_q - 1'b1;
            if (level_q > LVL_ONE) begin
              down_d = 1'b1;
              if (MISS_MODE != 0)
                level_d = level_q - 1'b1;
              else
                level_d = LVL_ONE;
            end
          end
        end else if (hit) begin
          if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (level_q < LVL_MAX) begin
              level_d = level_q + 1'b1;
              up_d    = 1'b1;
            end else begin
              state_d = S_WIN;
            end
          end
        end
      end
      S_WIN, S_OVER: begin
        if (start) begin
          state_d = S_PLAY;
          level_d = LVL_ONE;
          lives_d = LIFE_MAX;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_PLAY;
        level_d = LVL_ONE;
        lives_d = LIFE_MAX;
        cnt_d   = '0;
      end
    endcase
    win_d  = (state_d == S_WIN);
    over_d = (state_d == S_OVER);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_PLAY;
      level_q <= LVL_ONE;
      lives_q <= LIFE_MAX;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      win_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      down_q  <= down_d;
      win_q   <= win_d;
      over_q  <= over_d;
    end
  end

  assign level      = level_q;
  assign lives_left = lives_q;
  assign level_up   = up_q;
  assign level_down = down_q;
  assign win        = win_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_level_tracker.sv
// tb_level_tracker: three configurations driven in lockstep
// and compared against a behavioural game model.
module tb_level_tracker;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic hit = 1'b0;
  logic miss = 1'b0;
  logic start = 1'b0;

  always #5 clk = ~clk;

  // dut 0: defaults; dut 1: MISS_MODE=1; dut 2: 8 levels, 1 hit
  logic [2:0] lvl0, lvl1;
  logic [3:0] lvl2;
  logic [1:0] lf0, lf1, lf2;
  logic up0, up1, up2, dn0, dn1, dn2;
  logic w0, w1, w2, o0, o1, o2;

  level_tracker u0 (
    .clk(clk), .reset(reset), .hit(hit), .miss(miss),
    .start(start), .level(lvl0), .lives_left(lf0),
    .level_up(up0), .level_down(dn0), .win(w0),
    .game_over(o0));

  level_tracker #(.MISS_MODE(1)) u1 (
    .clk(clk), .reset(reset), .hit(hit), .miss(miss),
    .start(start), .level(lvl1), .lives_left(lf1),
    .level_up(up1), .level_down(dn1), .win(w1),
    .game_over(o1));

  level_tracker #(.NUM_LEVELS(8), .HITS_PER_LEVEL(1)) u2 (
    .clk(clk), .reset(reset), .hit(hit), .miss(miss),
    .start(start), .level(lvl2), .lives_left(lf2),
    .level_up(up2), .level_down(dn2), .win(w2),
    .game_over(o2));

  logic [11:0] obs [3];
  assign obs[0] = {4'(lvl0), 4'(lf0), up0, dn0, w0, o0};
  assign obs[1] = {4'(lvl1), 4'(lf1), up1, dn1, w1, o1};
  assign obs[2] = {lvl2, 4'(lf2), up2, dn2, w2, o2};

  int errors = 0;
  int checks = 0;

  // model: phase 0 playing, 1 won, 2 over
  int nl [3] = '{4, 4, 8};
  int hp [3] = '{2, 2, 1};
  int mm [3] = '{0, 1, 0};
  int m_lvl [3], m_lives [3], m_hits [3], m_ph [3];
  bit m_up [3], m_dn [3];

  function automatic void m_restart(int k);
    m_lvl[k] = 1; m_lives[k] = 3; m_hits[k] = 0;
    m_ph[k] = 0; m_up[k] = 0; m_dn[k] = 0;
  endfunction

  function automatic void m_step(int k, bit r, bit h,
                                 bit m, bit s);
    int nlv;
    m_up[k] = 0;
    m_dn[k] = 0;
    if (r) begin
      m_restart(k);
    end else if (m_ph[k] != 0) begin
      if (s) m_restart(k);
    end else if (m) begin
      m_hits[k] = 0;
      if (m_lives[k] == 1) begin
        m_lives[k] = 0;
        m_ph[k] = 2;
      end else begin
        m_lives[k] -= 1;
        nlv = (mm[k] == 1) ? m_lvl[k] - 1 : 1;
        if (nlv < 1) nlv = 1;
        m_dn[k] = (nlv < m_lvl[k]);
        m_lvl[k] = nlv;
      end
    end else if (h) begin
      m_hits[k] += 1;
      if (m_hits[k] == hp[k]) begin
        m_hits[k] = 0;
        if (m_lvl[k] < nl[k]) begin
          m_lvl[k] += 1;
          m_up[k] = 1;
        end else begin
          m_ph[k] = 1;
        end
      end
    end
  endfunction

  function automatic logic [11:0] expv(int k);
    return {4'(m_lvl[k]), 4'(m_lives[k]), m_up[k], m_dn[k],
            m_ph[k] == 1, m_ph[k] == 2};
  endfunction

  task automatic drive(bit r, bit h, bit m, bit s);
    reset = r; hit = h; miss = m; start = s;
    @(posedge clk);
    for (int k = 0; k < 3; k++) m_step(k, r, h, m, s);
    #1;
    reset = 0; hit = 0; miss = 0; start = 0;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== expv(k)) begin
        errors++;
        $display("FAIL reset dut%0d got=%h exp=%h",
                 k, obs[k], expv(k));
      end
    end
    checks++;
    if (obs[0] !== {4'd1, 4'd3, 4'b0000}) begin
      errors++;
      $display("FAIL reset_const got=%h exp=%h",
               obs[0], {4'd1, 4'd3, 4'b0000});
    end
  endtask

  task automatic test_climb_win();
    drive(1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      drive(0, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++;
          $display("FAIL climb hit%0d dut%0d got=%h exp=%h",
                   i, k, obs[k], expv(k));
        end
      end
      checks++;
      if (up0 !== (i == 2 || i == 4 || i == 6)) begin
        errors++;
        $display("FAIL climb_up hit%0d got=%b", i, up0);
      end
      drive(0, 0, 0, 0);
      checks++;
      if (up0 !== 1'b0 || obs[0] !== expv(0)) begin
        errors++;
        $display("FAIL climb_idle hit%0d got=%h exp=%h",
                 i, obs[0], expv(0));
      end
    end
    checks++;
    if (lvl0 !== 3'd4 || w0 !== 1'b1) begin
      errors++;
      $display("FAIL win4 level=%0d win=%b exp 4/1", lvl0, w0);
    end
    checks++;
    if (lvl2 !== 4'd8 || w2 !== 1'b1) begin
      errors++;
      $display("FAIL win8 level=%0d win=%b exp 8/1", lvl2, w2);
    end
  endtask

  task automatic test_miss();
    drive(1, 0, 0, 0);
    repeat (4) drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    checks++;
    if (lvl0 !== 3'd1 || lf0 !== 2'd2 || dn0 !== 1'b1) begin
      errors++;
      $display("FAIL miss_m0 lvl=%0d lives=%0d dn=%b exp 1/2/1",
               lvl0, lf0, dn0);
    end
    checks++;
    if (lvl1 !== 3'd2 || lf1 !== 2'd2 || dn1 !== 1'b1) begin
      errors++;
      $display("FAIL miss_m1 lvl=%0d lives=%0d dn=%b exp 2/2/1",
               lvl1, lf1, dn1);
    end
    drive(0, 1, 0, 0);
    checks++;
    if (lvl0 !== 3'd1 || up0 !== 1'b0 || dn0 !== 1'b0) begin
      errors++;
      $display("FAIL miss_cnt_clr lvl=%0d up=%b exp 1/0",
               lvl0, up0);
    end
    drive(0, 0, 1, 0);
    checks++;
    if (lvl1 !== 3'd1 || lf1 !== 2'd1 || dn1 !== 1'b1) begin
      errors++;
      $display("FAIL miss2_m1 lvl=%0d lives=%0d exp 1/1",
               lvl1, lf1);
    end
    drive(0, 0, 1, 0);
    checks++;
    if (o1 !== 1'b1 || lf1 !== 2'd0 || dn1 !== 1'b0 ||
        lvl1 !== 3'd1) begin
      errors++;
      $display("FAIL over_m1 over=%b lives=%0d dn=%b lvl=%0d",
               o1, lf1, dn1, lvl1);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== expv(k)) begin
        errors++;
        $display("FAIL miss_model dut%0d got=%h exp=%h",
                 k, obs[k], expv(k));
      end
    end
  endtask

  task automatic test_hit_miss_same();
    drive(1, 0, 0, 0);
    repeat (3) drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    checks++;
    if (lf0 !== 2'd2 || up0 !== 1'b0 || lvl0 !== 3'd1) begin
      errors++;
      $display("FAIL hitmiss lives=%0d up=%b lvl=%0d exp 2/0/1",
               lf0, up0, lvl0);
    end
    checks++;
    if (lvl1 !== 3'd1 || lf1 !== 2'd2 || up1 !== 1'b0) begin
      errors++;
      $display("FAIL hitmiss_m1 lvl=%0d lives=%0d exp 1/2",
               lvl1, lf1);
    end
    drive(0, 1, 0, 0);
    checks++;
    if (lvl1 !== 3'd1 || up1 !== 1'b0) begin
      errors++;
      $display("FAIL hitmiss_cnt lvl=%0d up=%b exp 1/0",
               lvl1, up1);
    end
  endtask

  task automatic test_over_start();
    drive(1, 0, 0, 0);
    repeat (3) drive(0, 0, 1, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    checks++;
    if (o0 !== 1'b1 || lf0 !== 2'd0 || w0 !== 1'b0) begin
      errors++;
      $display("FAIL over_hold over=%b lives=%0d exp 1/0",
               o0, lf0);
    end
    drive(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== {4'd1, 4'd3, 4'b0000}) begin
        errors++;
        $display("FAIL start dut%0d got=%h exp=%h",
                 k, obs[k], {4'd1, 4'd3, 4'b0000});
      end
    end
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    checks++;
    if (lvl0 !== 3'd2 || up0 !== 1'b1) begin
      errors++;
      $display("FAIL start_in_play lvl=%0d up=%b exp 2/1",
               lvl0, up0);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0);
    repeat (2) drive(0, 0, 1, 0);
    repeat (4) drive(0, 1, 0, 0);
    checks++;
    if (lvl0 !== 3'd3 || lf0 !== 2'd1) begin
      errors++;
      $display("FAIL mid_setup lvl=%0d lives=%0d exp 3/1",
               lvl0, lf0);
    end
    drive(1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== {4'd1, 4'd3, 4'b0000}) begin
        errors++;
        $display("FAIL reset_mid dut%0d got=%h exp=%h",
                 k, obs[k], {4'd1, 4'd3, 4'b0000});
      end
    end
  endtask

  task automatic test_random();
    bit r, h, m, s;
    int bad;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(99) < 2);
      h = ($urandom_range(99) < 45);
      m = ($urandom_range(99) < 12);
      s = ($urandom_range(99) < 8);
      drive(r, h, m, s);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++;
          bad++;
          if (bad < 10)
            $display("FAIL random c%0d dut%0d got=%h exp=%h",
                     i, k, obs[k], expv(k));
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) m_restart(k);
    @(negedge clk);
    test_reset();
    test_climb_win();
    test_miss();
    test_hit_miss_same();
    test_over_start();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
